// File: rtl/tff_bank_sync.sv
// Bank of WIDTH toggle flip-flops with toggle/count/load/clear modes, change flags and a
// saturating change-event counter. Define TFF_BANK_WRAP_FLAG_EN to add the counter wrap output.
module tff_bank_sync #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] load_val,
`ifdef TFF_BANK_WRAP_FLAG_EN
  output logic             wrap,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] toggled,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    ModeToggle = 2'b00,
    ModeCount  = 2'b01,
    ModeLoad   = 2'b10,
    ModeClear  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] toggled_q, toggled_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case (mode_e'(mode))
        ModeToggle: q_d = q_q ^ t;
        ModeCount:  q_d = t[0] ? q_q + WIDTH'(1) : q_q;
        ModeLoad:   q_d = load_val;
        ModeClear:  q_d = q_q & ~t;
        default:    q_d = q_q;
      endcase
    end
  end

  // q_d equals q_q whenever en is low, so the flags clear and the counter holds for free.
  always_comb begin
    toggled_d = q_d ^ q_q;
    evt_cnt_d = evt_cnt_q;
    if ((toggled_d != '0) && (evt_cnt_q != {CNT_W{1'b1}})) begin
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q       <= RESET_VAL;
      toggled_q <= '0;
      evt_cnt_q <= '0;
    end else begin
      q_q       <= q_d;
      toggled_q <= toggled_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

`ifdef TFF_BANK_WRAP_FLAG_EN
  logic wrap_q, wrap_d;

  // Only a counting edge out of all-ones is a wrap; loads or clears to zero are not.
  always_comb begin
    wrap_d = en && (mode_e'(mode) == ModeCount) && t[0] && (&q_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
`endif

  assign q       = q_q;
  assign toggled = toggled_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_tff_bank_sync.sv
// Directed self-checking bench for tff_bank_sync; a second instance with a 2-bit event
// counter covers saturation. Checks wrap when TFF_BANK_WRAP_FLAG_EN is defined.
module tb_tff_bank_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  t;
  logic [7:0]  load_val;
  logic [7:0]  q, toggled, q2, toggled2;
  logic [15:0] evt_cnt;
  logic [1:0]  evt_cnt2;
`ifdef TFF_BANK_WRAP_FLAG_EN
  logic        wrap, wrap2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tff_bank_sync #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5),
    .CNT_W    (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .t       (t),
    .load_val(load_val),
`ifdef TFF_BANK_WRAP_FLAG_EN
    .wrap    (wrap),
`endif
    .q       (q),
    .toggled (toggled),
    .evt_cnt (evt_cnt)
  );

  tff_bank_sync #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5),
    .CNT_W    (2)
  ) dut_sat (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .t       (t),
    .load_val(load_val),
`ifdef TFF_BANK_WRAP_FLAG_EN
    .wrap    (wrap2),
`endif
    .q       (q2),
    .toggled (toggled2),
    .evt_cnt (evt_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_main(input string tag, input logic [7:0] eq, input logic [7:0] et,
                             input logic [15:0] ec, input logic ew);
    check({tag, ".q"}, 32'(q), 32'(eq));
    check({tag, ".toggled"}, 32'(toggled), 32'(et));
    check({tag, ".evt_cnt"}, 32'(evt_cnt), 32'(ec));
`ifdef TFF_BANK_WRAP_FLAG_EN
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
`else
    if (ew) begin end
`endif
  endtask

  initial begin
    logic [7:0] q_exp;
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    reset = 1'b0; en = 1'b0; mode = 2'b00; t = 8'h00; load_val = 8'h00;
    #1;
    step(); step();
    expect_main("reset", 8'hA5, 8'h00, 16'd0, 1'b0);

    reset = 1'b1; en = 1'b0; t = 8'hFF;
    step(); step(); step();
    expect_main("hold_en0", 8'hA5, 8'h00, 16'd0, 1'b0);

    en = 1'b1; mode = 2'b00; t = 8'h0F;
    step();
    expect_main("toggle_0f", 8'hAA, 8'h0F, 16'd1, 1'b0);
    check("sat.evt_first", 32'(evt_cnt2), 32'd1);

    t = 8'h00;
    step();
    expect_main("toggle_00", 8'hAA, 8'h00, 16'd1, 1'b0);

    mode = 2'b10; load_val = 8'hFE; t = 8'h5A;
    step();
    expect_main("load_fe", 8'hFE, 8'h54, 16'd2, 1'b0);

    // Upper t bits are don't-care while counting.
    mode = 2'b01; t = 8'hF1;
    step();
    expect_main("count_ff", 8'hFF, 8'h01, 16'd3, 1'b0);
    step();
    expect_main("count_wrap", 8'h00, 8'hFF, 16'd4, 1'b1);
    step();
    expect_main("count_01", 8'h01, 8'h01, 16'd5, 1'b0);

    t = 8'hFE;
    step();
    expect_main("count_t0_low", 8'h01, 8'h00, 16'd5, 1'b0);

    mode = 2'b10; load_val = 8'h3C;
    step();
    expect_main("load_3c", 8'h3C, 8'h3D, 16'd6, 1'b0);

    mode = 2'b11; t = 8'h0C;
    step();
    expect_main("clear_0c", 8'h30, 8'h0C, 16'd7, 1'b0);

    mode = 2'b10; load_val = 8'h30;
    step();
    expect_main("load_same", 8'h30, 8'h00, 16'd7, 1'b0);

    mode = 2'b11; t = 8'hFF;
    step();
    expect_main("clear_to_zero", 8'h00, 8'h30, 16'd8, 1'b0);

    mode = 2'b01; t = 8'h01;
    step();
    expect_main("count_from_0", 8'h01, 8'h01, 16'd9, 1'b0);

    reset = 1'b0; mode = 2'b10; load_val = 8'hFF;
    step();
    expect_main("reset_mid", 8'hA5, 8'h00, 16'd0, 1'b0);
    check("sat.reset_mid", 32'(evt_cnt2), 32'd0);

    reset = 1'b1; mode = 2'b00; t = 8'h01;
    q_exp = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      step();
      q_exp = q_exp ^ 8'h01;
      check($sformatf("sat.evt[%0d]", i), 32'(evt_cnt2), 32'(sat_exp[i]));
      check($sformatf("sat.q[%0d]", i), 32'(q2), 32'(q_exp));
      check($sformatf("main.evt[%0d]", i), 32'(evt_cnt), 32'(i + 1));
    end

    en = 1'b0; t = 8'hFF; mode = 2'b01;
    step();
    expect_main("en0_after", 8'hA4, 8'h00, 16'd5, 1'b0);
    check("sat.en0_hold", 32'(evt_cnt2), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
